icache_responder: RTL and testbench
===================================

# icache_responder

Instruction-side memory responder for the fetch stage. It answers the fetch stage's per-cycle instruction address with the instruction word in the same cycle on a hit. On a miss it holds the fetch stage with a stall and refills a 4-word line from backing memory over a request/acknowledge handshake. It sits between the fetch stage's instruction-memory port and the shared backing memory model.

## Interface
Parameters:
- LINES, 16: number of direct-mapped lines; must be a power of 2, at least 2.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Addr_fIF  in  32  fetch address; combinational from fetch; bits [1:0] ignored.
- Instr_2IF  out  32  instruction word for Addr_fIF.
- Stall_2IF  out  1  fetch must freeze; high on a miss or while a refill is in progress.
- Flush  in  1  invalidate all lines; sampled each edge.
- Mem_Req  out  1  refill word request; registered.
- Mem_Addr  out  32  word address of the request; registered, word-aligned.
- Mem_Ack  in  1  backing memory accepts the request; Mem_Data is valid this cycle.
- Mem_Data  in  32  refill data word.
- Hit_Count  out  32  lookup hit counter; see Configuration.
- Miss_Count  out  32  miss counter; see Configuration.

## Operation
- Address split:
  - offset = Addr_fIF[3:2]
  - index = Addr_fIF[3+log2(LINES):4]
  - tag = the remaining upper bits
- Storage per line: valid bit, tag, 4 data words.
- Hit: line[index] is valid and its tag equals the tag of Addr_fIF.
- States:
  - IDLE: combinational lookup.
    - Hit: Instr_2IF = word[offset], Stall_2IF = 0.
    - Miss: Stall_2IF = 1. Latch the line base (Addr_fIF & ~0xF), cnt = 0, Mem_Req <= 1, Mem_Addr <= base. Next state FILL.
  - FILL: Stall_2IF = 1.
    - On each edge with Mem_Ack = 1: write Mem_Data to word[cnt], cnt++, Mem_Addr <= base + 4*cnt_new.
    - On the ack where cnt = 3: Mem_Req <= 0, set valid and tag unless the fill is poisoned, clear the poison flag, next state IDLE.
- Instr_2IF is don't-care while Stall_2IF = 1. The design drives the hit-mux output anyway.
- The fill always completes the latched line, even if Addr_fIF changes mid-fill. In IDLE, Addr_fIF is looked up fresh.
- Flush:
  - In IDLE: clears all valid bits at the edge.
  - In FILL: clears all valid bits and sets the poison flag. The burst still completes, but the line is not validated, so the next lookup re-misses.
- Flush and the final ack on the same edge: the fill is treated as poisoned.
- Mem_Ack is ignored when Mem_Req = 0.

## Timing
- Hit latency: 0 cycles; the fetch stage registers Instr_2IF at the same edge.
- Miss with zero-wait memory (Mem_Ack tied high):
  - miss seen in cycle 0;
  - edge 1 enters FILL;
  - acks at edges 2–5;
  - cycle 5 is IDLE and hits.
  - Stall_2IF is high in cycles 0–4, i.e. 5 cycles. Each memory wait cycle adds 1.
- Mem_Req and Mem_Addr stay stable until acknowledged.
- RESET high, at any time including mid-fill, immediately forces:
  - state IDLE; all valid bits 0; cnt 0; poison flag 0;
  - Mem_Req 0; Mem_Addr 0; counters 0.
  - While RESET is high, Stall_2IF = 0 and Instr_2IF = 0.
  - After release, the first lookup misses and restarts at word 0.

## Configuration
- ICACHE_STATS_EN defined:
  - Hit_Count increments on every edge where the state is IDLE with a hit and Flush = 0.
  - Miss_Count increments on every IDLE→FILL transition.
  - Both saturate at 0xFFFFFFFF.
- ICACHE_STATS_EN undefined: the ports remain and are driven constant 0; no counter logic is built.

## Test plan
- Reset vector miss:
  - Stimulus: RESET pulse, Addr_fIF = 0xBFC00000, Mem_Ack = 1, Mem_Data = 0x1000_0000 | Mem_Addr[7:0].
  - Required: Mem_Addr sequence 0xBFC00000/04/08/0C; Stall_2IF high for 5 cycles; then Instr_2IF = 0x10000000 with Stall_2IF = 0.
- Sequential hits: after the fill, Addr_fIF = 0xBFC00004, 0xBFC00008, 0xBFC0000C, one per cycle. Required: Instr_2IF = 0x10000004, 0x10000008, 0x1000000C; Mem_Req stays 0; Stall_2IF stays 0.
- Conflict miss (LINES = 16):
  - Addr_fIF = 0xBFC00100 (index 0, new tag) → refill from 0xBFC00100–0xBFC0010C.
  - Then Addr_fIF = 0xBFC00000 → misses again.
- Flush during fill:
  - Pulse Flush on the 2nd ack.
  - Required: the burst completes all 4 words; Stall_2IF stays high; a new burst starts at 0xBFC00000; then a hit.
- Reset mid-fill:
  - RESET high after the 2nd ack.
  - Required: Mem_Req = 0 immediately.
  - After release: Mem_Addr restarts at 0xBFC00000 and 4 acks are required before Stall_2IF = 0.
- Stats (ICACHE_STATS_EN defined): the first two scenarios back to back → Miss_Count = 1, Hit_Count = 4. With the macro undefined, both counters read 0.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: same-cycle hit lookup and a 4-word line refill on a miss.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_responder #(
    parameter int LINES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Addr_fIF,
    output logic [31:0] Instr_2IF,
    output logic        Stall_2IF,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Data,
    output logic [31:0] Hit_Count,
    output logic [31:0] Miss_Count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES*4];

    logic [27:0]      r_base;
    logic [1:0]       r_cnt;
    logic             r_poison;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;

    logic [1:0]       w_offset;
    logic [IDX_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [31:0]      w_rd_word;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic [1:0]       w_cnt_inc;
    logic             w_stall;
    logic             w_start;
    logic             w_ack;
    logic             w_last;
    logic             w_unused_bits;

    assign w_offset      = Addr_fIF[3:2];
    assign w_index       = Addr_fIF[4 +: IDX_W];
    assign w_tag         = Addr_fIF[31 -: TAG_W];
    assign w_unused_bits = ^Addr_fIF[1:0];

    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_rd_word  = r_data[{w_index, w_offset}];
    assign w_fill_idx = r_base[IDX_W-1:0];
    assign w_fill_tag = r_base[27 -: TAG_W];
    assign w_cnt_inc  = r_cnt + 2'd1;

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        w_ack        = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_hit) begin
                    w_stall      = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                w_stall = 1'b1;
                if (Mem_Ack && r_mem_req) begin
                    w_ack = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_last       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Reset masks the lookup so fetch sees a quiet port even though no line is valid.
    assign Stall_2IF = w_stall & ~RESET;
    assign Instr_2IF = RESET ? 32'h0 : w_rd_word;
    assign Mem_Req   = r_mem_req;
    assign Mem_Addr  = r_mem_addr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_base     <= '0;
            r_cnt      <= '0;
            r_poison   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            if (w_start) begin
                r_base     <= Addr_fIF[31:4];
                r_cnt      <= 2'd0;
                r_poison   <= 1'b0;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {Addr_fIF[31:4], 4'h0};
            end
            if (w_ack) begin
                r_cnt      <= w_cnt_inc;
                r_mem_addr <= {r_base, w_cnt_inc, 2'b00};
            end
            // A flush landing on the final ack is covered by skipping validation below.
            if (w_last) begin
                r_mem_req <= 1'b0;
                r_poison  <= 1'b0;
            end else if (r_state == S_FILL && Flush) begin
                r_poison <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
        end else if (Flush) begin
            r_valid <= '0;
        end else if (w_last && !r_poison) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Payload storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (w_ack) begin
            r_data[{w_fill_idx, r_cnt}] <= Mem_Data;
        end
        if (w_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && w_hit && !Flush && r_hit_cnt != 32'hFFFF_FFFF) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_start && r_miss_cnt != 32'hFFFF_FFFF) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign Hit_Count  = r_hit_cnt;
    assign Miss_Count = r_miss_cnt;
`else
    assign Hit_Count  = 32'h0;
    assign Miss_Count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: stimulus queues expected refill addresses and fetch words,
// a negedge monitor pops and compares them whenever the DUT acknowledges a request or releases a stall.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Addr_fIF = 32'h0;
    logic [31:0] Instr_2IF;
    logic        Stall_2IF;
    logic        Flush;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Data;
    logic [31:0] Hit_Count;
    logic [31:0] Miss_Count;

    logic        flush_idle = 1'b0;
    logic        flush_ack  = 1'b0;
    logic        wait_mode  = 1'b0;
    logic        ph         = 1'b0;
    int          flush_at_ack = 0;
    int          ack_idx = 0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_instr[$];

`ifdef ICACHE_STATS_EN
    localparam logic [31:0] EXP_HIT4  = 32'd4;
    localparam logic [31:0] EXP_MISS1 = 32'd1;
    localparam logic [31:0] EXP_MISS3 = 32'd3;
`else
    localparam logic [31:0] EXP_HIT4  = 32'd0;
    localparam logic [31:0] EXP_MISS1 = 32'd0;
    localparam logic [31:0] EXP_MISS3 = 32'd0;
`endif

    icache_responder #(.LINES(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Addr_fIF   (Addr_fIF),
        .Instr_2IF  (Instr_2IF),
        .Stall_2IF  (Stall_2IF),
        .Flush      (Flush),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_Ack    (Mem_Ack),
        .Mem_Data   (Mem_Data),
        .Hit_Count  (Hit_Count),
        .Miss_Count (Miss_Count)
    );

    always #5 CLK = ~CLK;

    // Backing memory: zero-wait by default, one wait cycle per word in wait_mode.
    assign Flush    = flush_idle | flush_ack;
    assign Mem_Ack  = wait_mode ? (Mem_Req & ph) : 1'b1;
    assign Mem_Data = 32'h1000_0000 | {20'h0, Mem_Addr[11:0]};

    always @(posedge CLK) ph <= Mem_Req ? ~ph : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && Mem_Req && Mem_Ack) begin
            if (q_addr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got Mem_Addr %h, expected no request", Mem_Addr);
            end else begin
                check("mem_addr", Mem_Addr, q_addr.pop_front());
            end
        end
        if (!RESET && !Stall_2IF && q_instr.size() > 0) begin
            check("instr", Instr_2IF, q_instr.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (flush_at_ack == 0) begin
            ack_idx = 0;
        end else if (Mem_Req && Mem_Ack) begin
            ack_idx++;
            if (ack_idx == flush_at_ack) begin
                flush_ack = 1'b1;
                @(posedge CLK);
                #1;
                flush_ack = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                         input int exp_stall, input int n_bursts);
        int  stalls = 0;
        bit  done = 0;
        Addr_fIF = a;
        for (int b = 0; b < n_bursts; b++)
            for (int w = 0; w < 4; w++)
                q_addr.push_back({a[31:4], 4'h0} + 32'(4 * w));
        q_instr.push_back(exp_instr);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (Stall_2IF) stalls++;
            else done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout: got stall still high after 60 cycles, expected release for %h", a);
        end else begin
            check("stall_cycles", 32'(stalls), 32'(exp_stall));
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        bit drained;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_stall", {31'h0, Stall_2IF}, 32'h0);
        check("rst_instr", Instr_2IF, 32'h0);
        check("rst_req", {31'h0, Mem_Req}, 32'h0);
        check("rst_addr", Mem_Addr, 32'h0);
        check("rst_hits", Hit_Count, 32'h0);
        check("rst_misses", Miss_Count, 32'h0);

        // Reset vector miss, then sequential hits.
        RESET = 1'b0;
        fetch(32'hBFC0_0000, 32'h1000_0000, 5, 1);
        fetch(32'hBFC0_0004, 32'h1000_0004, 0, 0);
        fetch(32'hBFC0_0008, 32'h1000_0008, 0, 0);
        fetch(32'hBFC0_000C, 32'h1000_000C, 0, 0);
        check("hit_count", Hit_Count, EXP_HIT4);
        check("miss_count", Miss_Count, EXP_MISS1);

        // Conflict on index 0.
        fetch(32'hBFC0_0100, 32'h1000_0100, 5, 1);
        fetch(32'hBFC0_0104, 32'h1000_0104, 0, 0);
        fetch(32'hBFC0_0000, 32'h1000_0000, 5, 1);

        // Flush in IDLE, then flush on the 2nd ack of the refill: two full bursts.
        flush_idle = 1'b1;
        @(posedge CLK);
        #1;
        flush_idle = 1'b0;
        flush_at_ack = 2;
        fetch(32'hBFC0_0000, 32'h1000_0000, 10, 2);
        flush_at_ack = 0;
        fetch(32'hBFC0_0008, 32'h1000_0008, 0, 0);

        // Reset after the 2nd ack of a refill.
        Addr_fIF = 32'hBFC0_0040;
        q_addr.push_back(32'hBFC0_0040);
        q_addr.push_back(32'hBFC0_0044);
        drained = 0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge CLK);
            #1;
            if (q_addr.size() == 0) drained = 1;
        end
        if (!drained) begin
            n_checks++;
            n_fail++;
            $display("FAIL midfill_timeout: got %0d pending acks, expected 0", q_addr.size());
            q_addr.delete();
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check("midrst_req", {31'h0, Mem_Req}, 32'h0);
        check("midrst_addr", Mem_Addr, 32'h0);
        check("midrst_stall", {31'h0, Stall_2IF}, 32'h0);
        check("midrst_instr", Instr_2IF, 32'h0);
        check("midrst_misses", Miss_Count, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        fetch(32'hBFC0_0040, 32'h1000_0040, 5, 1);
        fetch(32'hBFC0_0000, 32'h1000_0000, 5, 1);

        // One wait cycle per refill word.
        wait_mode = 1'b1;
        fetch(32'hBFC0_0060, 32'h1000_0060, 9, 1);
        fetch(32'hBFC0_006C, 32'h1000_006C, 0, 0);
        wait_mode = 1'b0;

        check("final_misses", Miss_Count, EXP_MISS3);
        check("addr_queue_left", 32'(q_addr.size()), 32'h0);
        check("instr_queue_left", 32'(q_instr.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
